// File: rtl/sliding_window_buffer_pkg.sv
// rtl/sliding_window_buffer_pkg.sv - FSM encoding and sizing helpers for the sliding window buffer
package window_buf_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t STREAM = 2'd1;
   localparam state_t DONE   = 2'd2;

   // counter width that stays legal when the range collapses to a single value
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // number of window positions along one image axis
   function automatic int out_cnt(input int img, input int ker, input int stride);
      return (img - ker) / stride + 1;
   endfunction

endpackage

// File: rtl/sliding_window_buffer_if.sv
// rtl/sliding_window_buffer_if.sv - pixel-in / window-out handshake bundle
interface sliding_window_buffer_if #(
   parameter int KER_SIZE = 5,
   parameter int BITWIDTH = 16,
   parameter int NFMAPS   = 1
);

   logic                                      in_valid;
   logic                                      in_flush;
   logic [NFMAPS*BITWIDTH-1:0]                in_act;
   logic                                      in_ready;
   logic                                      out_valid;
   logic                                      out_ready;
   logic [KER_SIZE*KER_SIZE*NFMAPS*BITWIDTH-1:0] out_act;
   logic                                      out_last;

   modport master (
      output in_valid, in_flush, in_act, out_ready,
      input  in_ready, out_valid, out_act, out_last
   );

   modport slave (
      input  in_valid, in_flush, in_act, out_ready,
      output in_ready, out_valid, out_act, out_last
   );

endinterface

// File: rtl/sliding_window_buffer_line_mem.sv
// rtl/sliding_window_buffer_line_mem.sv - one image row of pixels, combinational read, synchronous write
module line_mem
   import window_buf_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int WIDTH = 16,
   parameter int AW    = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // read returns the old entry in the same cycle the new one is written
   assign rd_data = mem[addr];

   // store the incoming pixel at the current column
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/sliding_window_buffer.sv
// rtl/sliding_window_buffer.sv - raster pixel stream to strided KxK multi-channel windows
module sliding_window_buffer
   import window_buf_pkg::*;
#(
   parameter int KER_SIZE = 5,
   parameter int BITWIDTH = 16,
   parameter int NFMAPS   = 1,
   parameter int STRIDE   = 1,
   parameter int IMG_W    = 32,
   parameter int IMG_H    = 32
) (
   input logic                    clk,
   input logic                    rstn,
   sliding_window_buffer_if.slave bus
);

   localparam int PIX_W     = NFMAPS * BITWIDTH;
   localparam int WIN_W     = KER_SIZE * KER_SIZE * PIX_W;
   localparam int CW        = cnt_w(IMG_W);
   localparam int RW        = cnt_w(IMG_H);
   localparam int PW        = cnt_w(STRIDE);
   localparam int OUT_W_CNT = out_cnt(IMG_W, KER_SIZE, STRIDE);
   localparam int OUT_H_CNT = out_cnt(IMG_H, KER_SIZE, STRIDE);

   // geometry must land the last window exactly on the last pixel
   if (KER_SIZE < 2) begin : g_chk_ker
      $error("sliding_window_buffer: KER_SIZE must be at least 2");
   end
   if (STRIDE < 1) begin : g_chk_stride
      $error("sliding_window_buffer: STRIDE must be at least 1");
   end
   if ((IMG_W - KER_SIZE) % STRIDE != 0 || OUT_W_CNT < 1) begin : g_chk_w
      $error("sliding_window_buffer: IMG_W does not fit KER_SIZE/STRIDE");
   end
   if ((IMG_H - KER_SIZE) % STRIDE != 0 || OUT_H_CNT < 1) begin : g_chk_h
      $error("sliding_window_buffer: IMG_H does not fit KER_SIZE/STRIDE");
   end

   state_t           state;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [PW-1:0]    col_ph;
   logic [PW-1:0]    row_ph;

   logic [PIX_W-1:0] win     [KER_SIZE][KER_SIZE];
   logic [PIX_W-1:0] win_nxt [KER_SIZE][KER_SIZE];
   logic [PIX_W-1:0] line_rd [KER_SIZE-1];
   logic [PIX_W-1:0] col_in  [KER_SIZE];
   logic [WIN_W-1:0] win_flat;

   logic             out_valid_q;
   logic             out_last_q;
   logic [WIN_W-1:0] out_act_q;

   logic             in_ready_i;
   logic             accept;
   logic             col_end;
   logic             row_end;
   logic             last_pix;
   logic             emit;

   function automatic logic [PW-1:0] ph_next(input logic [PW-1:0] ph);
      return (ph == PW'(STRIDE - 1)) ? '0 : ph + 1'b1;
   endfunction

   assign in_ready_i = (state != DONE) && (!out_valid_q || bus.out_ready);
   assign accept     = bus.in_valid && in_ready_i && !bus.in_flush;
   assign col_end    = (col == CW'(IMG_W - 1));
   assign row_end    = (row == RW'(IMG_H - 1));
   assign last_pix   = col_end && row_end;
   assign emit       = accept
                    && (row >= RW'(KER_SIZE - 1)) && (col >= CW'(KER_SIZE - 1))
                    && (row_ph == '0) && (col_ph == '0);

   assign bus.in_ready  = in_ready_i;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_act   = out_act_q;

   // line j holds image row (current - (K-1) + j); each accept ages the column by one line
   for (genvar j = 0; j < KER_SIZE - 1; j++) begin : g_line
      logic [PIX_W-1:0] wr_data;
      if (j == KER_SIZE - 2) begin : g_newest
         assign wr_data = bus.in_act;
      end else begin : g_older
         assign wr_data = line_rd[j + 1];
      end
      line_mem #(
         .DEPTH (IMG_W),
         .WIDTH (PIX_W)
      ) u_mem (
         .clk     (clk),
         .we      (accept),
         .addr    (col),
         .wr_data (wr_data),
         .rd_data (line_rd[j])
      );
   end

   // column entering the window: stored rows on top, live pixel at the bottom
   for (genvar r = 0; r < KER_SIZE; r++) begin : g_col_in
      if (r == KER_SIZE - 1) begin : g_live
         assign col_in[r] = bus.in_act;
      end else begin : g_stored
         assign col_in[r] = line_rd[r];
      end
   end

   // window after this accept: shift left, new column on the right
   always_comb begin
      for (int r = 0; r < KER_SIZE; r++) begin
         for (int c = 0; c < KER_SIZE - 1; c++) begin
            win_nxt[r][c] = win[r][c + 1];
         end
         win_nxt[r][KER_SIZE - 1] = col_in[r];
      end
   end

   // flatten with r=0 oldest row and c=0 leftmost column in the low bits
   always_comb begin
      win_flat = '0;
      for (int r = 0; r < KER_SIZE; r++) begin
         for (int c = 0; c < KER_SIZE; c++) begin
            win_flat[(r * KER_SIZE + c) * PIX_W +: PIX_W] = win_nxt[r][c];
         end
      end
   end

   // shift-register window advances on every accepted pixel
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < KER_SIZE; r++) begin
            for (int c = 0; c < KER_SIZE; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < KER_SIZE; r++) begin
            for (int c = 0; c < KER_SIZE; c++) begin
               win[r][c] <= win_nxt[r][c];
            end
         end
      end
   end

   // raster position, stride phases and frame state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col    <= '0;
         row    <= '0;
         col_ph <= '0;
         row_ph <= '0;
         state  <= IDLE;
      end else if (bus.in_flush) begin
         col    <= '0;
         row    <= '0;
         col_ph <= '0;
         row_ph <= '0;
         state  <= IDLE;
      end else begin
         if (accept) begin
            if (col_end) begin
               col    <= '0;
               col_ph <= '0;
               if (row_end) begin
                  row    <= '0;
                  row_ph <= '0;
               end else begin
                  row <= row + 1'b1;
                  if (row >= RW'(KER_SIZE - 1)) begin
                     row_ph <= ph_next(row_ph);
                  end
               end
            end else begin
               col <= col + 1'b1;
               if (col >= CW'(KER_SIZE - 1)) begin
                  col_ph <= ph_next(col_ph);
               end
            end
         end
         case (state)
            IDLE:    if (accept) state <= last_pix ? DONE : STREAM;
            STREAM:  if (accept && last_pix) state <= DONE;
            DONE:    if (out_valid_q && bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // single output stage; holds while the consumer stalls
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_act_q   <= '0;
      end else if (bus.in_flush) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (emit) begin
         out_valid_q <= 1'b1;
         out_last_q  <= last_pix;
         out_act_q   <= win_flat;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end
   end

endmodule
